// File: rtl/self_sync_descrambler.sv
// rtl/self_sync_descrambler.sv - serial self-synchronising descrambler with lock tracking
//
// Recovers each data bit as in_bit XOR parity(received-bit history & TAPS),
// the inverse of an XOR-feedback scrambler with the same taps. One output
// register stage with valid/ready on both sides.
//
// Ports:
//   clk       in   clock, all logic on posedge
//   rst       in   synchronous reset, active-high
//   in_valid  in   upstream scrambled bit valid
//   in_ready  out  block can accept in_bit this cycle
//   in_bit    in   scrambled bit
//   out_valid out  descrambled bit valid
//   out_ready in   downstream accepts out_bit this cycle
//   out_bit   out  descrambled bit
//   locked    out  history register fully filled with received bits
//
// Build option: DESCRAMBLER_DROP_UNLOCKED_EN
//   defined   - beats accepted before lock only fill the history; they are
//               swallowed and never presented on the output.
//   undefined - every accepted beat is forwarded; locked is informational.

module self_sync_descrambler #(
    parameter int                  LFSR_LEN  = 7,
    parameter logic [LFSR_LEN-1:0] TAPS      = 7'b110_0000,
    parameter int                  LOCK_BITS = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_bit,
    output logic out_valid,
    input  logic out_ready,
    output logic out_bit,
    output logic locked
);

    localparam logic [0:0] ST_ACQUIRE = 1'b0;
    localparam logic [0:0] ST_TRACK   = 1'b1;
    localparam logic [7:0] LOCK_CNT   = 8'(LOCK_BITS);

    // sr_q[k-1] holds the scrambled bit accepted k beats ago.
    logic [LFSR_LEN-1:0] sr_q, sr_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [0:0]          state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic                out_bit_q, out_bit_d;
    logic                acc;
    logic                fwd;
    logic                d_bit;

    // Parity taken on the pre-shift history, so the current bit never feeds itself.
    assign d_bit = in_bit ^ (^(sr_q & TAPS));

`ifdef DESCRAMBLER_DROP_UNLOCKED_EN
    // Nothing is ever presented in ACQUIRE, so the input is always free there.
    assign in_ready = (state_q == ST_ACQUIRE) | ~out_valid_q | out_ready;
    assign fwd      = (state_q == ST_TRACK);
`else
    assign in_ready = ~out_valid_q | out_ready;
    assign fwd      = 1'b1;
`endif

    assign acc = in_valid & in_ready;

    always_comb begin
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;

        if (acc) begin
            sr_d = {sr_q[LFSR_LEN-2:0], in_bit};
            if (cnt_q != LOCK_CNT) begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        if (state_q == ST_ACQUIRE && cnt_d == LOCK_CNT) begin
            state_d = ST_TRACK;
        end

        // A new accepted beat reloads the register even while the old bit is
        // being taken, giving one bit per cycle without a bubble.
        if (acc && fwd) begin
            out_valid_d = 1'b1;
            out_bit_d   = d_bit;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q        <= '0;
            cnt_q       <= 8'd0;
            state_q     <= ST_ACQUIRE;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign locked    = (state_q == ST_TRACK);

endmodule
